// File: rtl/int_div_iterative_if.sv
// Request/response stream bundle for the iterative divider.
// The divider sits on the slave side; the requester/consumer uses master.
interface int_div_iterative_if;
  logic        istream_val;
  logic        istream_rdy;
  logic [63:0] istream_msg;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [63:0] ostream_msg;

  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );

  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );
endinterface

// File: rtl/int_div_iterative.sv
// Iterative 32-bit restoring divider, one quotient bit per cycle.
// Returns {remainder, quotient}; SIGNED selects RISC-V DIV/REM or DIVU/REMU semantics.
module int_div_iterative #(
  parameter bit SIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  int_div_iterative_if.slave  io
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [4:0]          counter;
  logic [2*DATA_W-1:0] msg_r;

  logic [DATA_W-1:0]   rem_r;
  logic [DATA_W-1:0]   quo_r;
  logic [DATA_W-1:0]   dvs_r;
  logic [DATA_W-1:0]   dvd_raw_r;
  logic                neg_q_r;
  logic                neg_r_r;
  logic                dz_r;

  logic [DATA_W-1:0]   in_dvd;
  logic [DATA_W-1:0]   in_dvs;
  logic                sgn_dvd;
  logic                sgn_dvs;
  logic [DATA_W-1:0]   mag_dvd;
  logic [DATA_W-1:0]   mag_dvs;

  logic [DATA_W:0]     trial;
  logic                fits;
  logic [DATA_W-1:0]   rem_next;
  logic [DATA_W-1:0]   quo_next;

  // Sign-magnitude conversion; -0x80000000 wraps back to 0x80000000, which is the
  // correct unsigned magnitude.
  assign in_dvd  = io.istream_msg[63:32];
  assign in_dvs  = io.istream_msg[31:0];
  assign sgn_dvd = SIGNED ? in_dvd[DATA_W-1] : 1'b0;
  assign sgn_dvs = SIGNED ? in_dvs[DATA_W-1] : 1'b0;
  assign mag_dvd = sgn_dvd ? -in_dvd : in_dvd;
  assign mag_dvs = sgn_dvs ? -in_dvs : in_dvs;

  // Restoring step: the partial remainder is always below the divisor, so after
  // a successful subtract the low 32 bits hold the exact result.
  assign trial    = {rem_r, quo_r[DATA_W-1]};
  assign fits     = (trial >= {1'b0, dvs_r});
  assign rem_next = fits ? (trial[DATA_W-1:0] - dvs_r) : trial[DATA_W-1:0];
  assign quo_next = {quo_r[DATA_W-2:0], fits};

  assign io.istream_rdy = (state == IDLE) && !reset;
  assign io.ostream_val = (state == DONE) && !reset;
  assign io.ostream_msg = msg_r;

  function automatic logic [2*DATA_W-1:0] fixup(
    input logic              dz,
    input logic              neg_q,
    input logic              neg_r,
    input logic [DATA_W-1:0] q,
    input logic [DATA_W-1:0] r,
    input logic [DATA_W-1:0] raw_dvd
  );
    logic [DATA_W-1:0] qf;
    logic [DATA_W-1:0] rf;
    if (dz) begin
      qf = '1;
      rf = raw_dvd;
    end else begin
      qf = neg_q ? -q : q;
      rf = neg_r ? -r : r;
    end
    return {rf, qf};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      msg_r   <= '0;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.istream_val) begin
            rem_r     <= '0;
            quo_r     <= mag_dvd;
            dvs_r     <= mag_dvs;
            dvd_raw_r <= in_dvd;
            neg_r_r   <= sgn_dvd;
            neg_q_r   <= sgn_dvd ^ sgn_dvs;
            dz_r      <= (in_dvs == '0);
            counter   <= '0;
            state     <= CALC;
          end
        end
        CALC: begin
          rem_r   <= rem_next;
          quo_r   <= quo_next;
          counter <= counter + 5'd1;
          if (counter == 5'd31) begin
            msg_r <= fixup(dz_r, neg_q_r, neg_r_r, quo_next, rem_next, dvd_raw_r);
            state <= DONE;
          end
        end
        DONE: begin
          if (io.ostream_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div_iterative.sv
// Bench for int_div_iterative: signed and unsigned instances run in lockstep on
// identical stimulus; fixed vectors, corner sequences and random traffic.
module tb_int_div_iterative;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int_div_iterative_if if_s ();
  int_div_iterative_if if_u ();

  int_div_iterative #(.SIGNED(1'b1)) u_dut_s (.clk(clk), .reset(reset), .io(if_s));
  int_div_iterative #(.SIGNED(1'b0)) u_dut_u (.clk(clk), .reset(reset), .io(if_u));

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_s;
    logic [63:0] exp_u;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference behaviour straight from the arithmetic definition.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic drive_in(input logic val, input logic [63:0] msg);
    if_s.istream_val = val;
    if_u.istream_val = val;
    if_s.istream_msg = msg;
    if_u.istream_msg = msg;
  endtask

  task automatic set_ordy(input logic v);
    if_s.ostream_rdy = v;
    if_u.ostream_rdy = v;
  endtask

  // Present a request and return at the negedge just after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    drive_in(1'b1, {a, b});
    while (!(if_s.istream_rdy && if_u.istream_rdy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      $display("FAIL accept_timeout: got %0d cycles, expected < 100", n);
      $fatal(1);
    end
    @(negedge clk);
    drive_in(1'b0, 64'd0);
  endtask

  // Count cycles from the accept edge until a result is valid on both units.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!(if_s.ostream_val && if_u.ostream_val) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) begin
      $display("FAIL result_timeout: got %0d cycles, expected 33", lat);
      $fatal(1);
    end
  endtask

  task automatic run_txn(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_s, input logic [63:0] exp_u);
    int lat;
    send(a, b);
    wait_result(lat);
    check({name, "_lat"}, 64'(lat), 64'd33);
    check({name, "_s"}, if_s.ostream_msg, exp_s);
    check({name, "_u"}, if_u.ostream_msg, exp_u);
    @(negedge clk);
    check({name, "_rdy_next"}, {62'd0, if_s.istream_rdy, if_u.istream_rdy}, 64'd3);
  endtask

  vec_t vecs [8];

  initial begin
    logic [63:0] held_s;
    logic [63:0] held_u;
    logic [31:0] ra;
    logic [31:0] rb;
    int lat;
    bit saw_val;

    vecs[0] = '{32'd100,        32'd7,          64'h00000002_0000000E, 64'h00000002_0000000E};
    vecs[1] = '{32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 64'h00000001_7FFFFFFC};
    vecs[2] = '{32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 64'h00000007_00000000};
    vecs[3] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  64'hFFFFFFFF_00000003, 64'hFFFFFFF9_00000000};
    vecs[4] = '{32'hFFFF_FFFF,  32'd2,          64'hFFFFFFFF_00000000, 64'h00000001_7FFFFFFF};
    vecs[5] = '{32'h1234_5678,  32'd0,          64'h12345678_FFFFFFFF, 64'h12345678_FFFFFFFF};
    vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 64'h80000000_00000000};
    vecs[7] = '{32'd0,          32'd5,          64'h00000000_00000000, 64'h00000000_00000000};

    drive_in(1'b0, 64'd0);
    set_ordy(1'b1);

    repeat (3) @(negedge clk);
    check("reset_rdy_val", {60'd0, if_s.istream_rdy, if_u.istream_rdy, if_s.ostream_val, if_u.ostream_val}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_msg_s", if_s.ostream_msg, 64'd0);
    check("post_reset_msg_u", if_u.ostream_msg, 64'd0);
    check("post_reset_rdy", {62'd0, if_s.istream_rdy, if_u.istream_rdy}, 64'd3);

    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_s, vecs[i].exp_u);

    // Backpressure with a new request waiting on the input.
    set_ordy(1'b0);
    send(32'd100, 32'd7);
    wait_result(lat);
    check("bp_lat", 64'(lat), 64'd33);
    held_s = if_s.ostream_msg;
    held_u = if_u.ostream_msg;
    check("bp_msg_s", held_s, 64'h00000002_0000000E);
    drive_in(1'b1, {32'd1000, 32'd33});
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d_val_rdy", i),
            {60'd0, if_s.ostream_val, if_u.ostream_val, if_s.istream_rdy, if_u.istream_rdy}, 64'hC);
      check($sformatf("bp_hold%0d_msg_s", i), if_s.ostream_msg, held_s);
      check($sformatf("bp_hold%0d_msg_u", i), if_u.ostream_msg, held_u);
      @(negedge clk);
    end
    set_ordy(1'b1);
    @(negedge clk);
    check("bp_idle_rdy", {60'd0, if_s.ostream_val, if_u.ostream_val, if_s.istream_rdy, if_u.istream_rdy}, 64'h3);
    @(negedge clk);
    drive_in(1'b0, 64'd0);
    check("bp_accepted", {62'd0, if_s.istream_rdy, if_u.istream_rdy}, 64'd0);
    wait_result(lat);
    check("bp_queued_lat", 64'(lat), 64'd33);
    check("bp_queued_s", if_s.ostream_msg, 64'h0000000A_0000001E);
    check("bp_queued_u", if_u.ostream_msg, 64'h0000000A_0000001E);
    @(negedge clk);

    // Reset during CALC step 10 abandons the job.
    send(32'd123, 32'd4);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {60'd0, if_s.istream_rdy, if_u.istream_rdy, if_s.ostream_val, if_u.ostream_val}, 64'd0);
    reset = 1'b0;
    saw_val = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      saw_val |= (if_s.ostream_val | if_u.ostream_val);
    end
    check("midreset_no_result", {63'd0, saw_val}, 64'd0);
    run_txn("after_reset", 32'd1000, 32'd33, 64'h0000000A_0000001E, 64'h0000000A_0000001E);

    // Random traffic against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 20);
        2: rb = -$urandom_range(1, 20);
        default: rb = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      if (i == 0) ra = 32'h8000_0000;
      run_txn($sformatf("rnd%0d", i), ra, rb, ref_div(1'b1, ra, rb), ref_div(1'b0, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
